// File: rtl/rc4_pkg.sv
// Shared constants and FSM encoding for the RC4 XOR unit.
// Keystream geometry and FIFO sizing live here.
package rc4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int NIBBLES         = 16;
  localparam int WORDS_PER_FETCH = 2;
  localparam int NIB_PER_WORD    = NIBBLES / WORDS_PER_FETCH;
  localparam int FIFO_DEPTH      = 2;
  localparam int WORD_W          = 32;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Small keystream word FIFO between the packer and the XOR stage.
// The producer guarantees it never pushes while full without a pop.
module rc4_ks_fifo
  import rc4_pkg::*;
(
  input  logic              clk,
  input  logic              reset_1,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [PW:0]       cnt_q;
  logic              do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and occupancy; reset discards all contents.
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      unique case ({push_i, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rc4_xor_unit.sv
// Fetches 16-nibble keystreams from the RC4 generator, packs them into
// 32-bit words and XORs each accepted data word with the next one.
module rc4_xor_unit
  import rc4_pkg::*;
(
  input  logic        clk,
  input  logic        reset_1,
  output logic        ks_start,
  input  logic        ks_done,
  output logic [3:0]  ks_addr,
  input  logic [3:0]  ks_nib,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int AW = $clog2(NIBBLES);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(NIB_PER_WORD);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ks_start_q, ks_start_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [SW-1:0]     slot;
  logic              push, fifo_push, pop;
  logic              fifo_empty, fifo_full;
  logic [WORD_W-1:0] head;

  // Cycle cnt_q carries the nibble addressed in cycle cnt_q-1.
  assign slot = cnt_q[SW-1:0] - 1'b1;

  assign ks_start  = ks_start_q;
  assign ks_addr   = (state_q == ST_FETCH && cnt_q < CW'(NIBBLES))
                   ? cnt_q[AW-1:0] : '0;
  assign in_ready  = !fifo_empty && (!out_valid_q || out_ready);
  assign pop       = in_valid && in_ready;
  assign fifo_push = push && !fifo_full;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  rc4_ks_fifo u_fifo (
    .clk        (clk),
    .reset_1    (reset_1),
    .push_i     (fifo_push),
    .push_data_i(pack_d),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  // Control FSM: request, wait, fetch/pack, then drain before re-request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ks_start_d = 1'b0;
    pack_d     = pack_q;
    push       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d    = ST_GEN;
        ks_start_d = 1'b1;
      end
      ST_GEN: begin
        if (ks_done) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0) begin
          // Shift-in keeps nibble 0 of each word in the MSBs.
          pack_d = {pack_q[WORD_W-5:0], ks_nib};
          push   = (slot == SW'(NIB_PER_WORD - 1));
        end
        if (cnt_q == CW'(NIBBLES)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d    = ST_GEN;
          ks_start_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: load on accept, clear once taken downstream.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ head;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any partial word and pending output.
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ks_start_q  <= 1'b0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ks_start_q  <= ks_start_d;
      pack_q      <= pack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
